// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the front-end pipeline stages.
// Holds the fetch entry type passed from fetch to decode.
package riscv_pkg;

   localparam int XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and combinational head read.
// Used both as the prefetch buffer and as the in-flight PC queue.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter type T = fetch_entry_t,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  T              din,
   output T              head,
   output logic [CW-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T              mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst_n && !flush) assert (!(push && !do_push));
   end

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction fetch: owns the PC, keeps imem requests credit-limited,
// buffers returned words with their PC and flushes on branch redirects.
module if_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   input  logic            id_ready
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   logic [XLEN-1:0] fetch_pc;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   drop_cnt;
   logic [CW-1:0]   fifo_count;
   logic [OW-1:0]   pcq_count;
   logic [XLEN-1:0] pcq_head;
   logic [XLEN-1:0] in_use;
   fetch_entry_t    fifo_head;
   fetch_entry_t    fifo_din;
   logic            issue;
   logic            rsp;
   logic            rsp_keep;
   logic            pop;

   // Slots already promised: buffered words plus responses that will be kept.
   assign in_use = XLEN'(fifo_count) + XLEN'(outstanding) - XLEN'(drop_cnt);

   assign imem_req  = rst_n && !redirect_valid
                      && (outstanding < OW'(MAX_OUTSTANDING))
                      && (in_use < XLEN'(DEPTH));
   assign imem_addr = fetch_pc;
   assign issue     = imem_req && imem_gnt;

   // A response with nothing outstanding is a leftover from before reset.
   assign rsp      = imem_rvalid && (outstanding != '0);
   assign rsp_keep = rsp && (drop_cnt == '0) && !redirect_valid;
   assign pop      = if_valid && id_ready && !redirect_valid;
   assign fifo_din = '{pc: pcq_head, instr: imem_rdata};

   assign if_valid = (fifo_count != '0);
   assign if_instr = if_valid ? fifo_head.instr : NOP_INSTR;
   assign if_pc    = if_valid ? fifo_head.pc : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + OW'(issue) - OW'(rsp);
         if (redirect_valid) begin
            fetch_pc <= align_word(redirect_pc);
            drop_cnt <= outstanding - OW'(rsp);
         end else begin
            if (issue) fetch_pc <= fetch_pc + 32'd4;
            if (rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
         end
      end
   end

   // PC queue only ever holds the requests whose responses will be kept.
   always_ff @(posedge clk) begin
      if (rst_n) assert (pcq_count == outstanding - drop_cnt);
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (fetch_entry_t)
   ) u_ifq (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rsp_keep),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (fifo_din),
      .head  (fifo_head),
      .count (fifo_count)
   );

   fetch_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .T     (logic [XLEN-1:0])
   ) u_pcq (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (issue),
      .pop   (rsp_keep),
      .flush (redirect_valid),
      .din   (fetch_pc),
      .head  (pcq_head),
      .count (pcq_count)
   );

endmodule
